eclk_phase_align: RTL and testbench



---
 rtl/eclk_phase_align.sv | 261 ++++++++++++++++++++++++++
 tb/tb_eclk_phase_align.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eclk_phase_align.sv
// rtl/eclk_phase_align.sv - PLL phase alignment controller driven by filtered eclk status
//
// Purpose:
//   Steps the PLL output phase forward one step at a time. After each step it
//   clears the downstream jitter filter, waits for it to refill, and samples
//   the filtered status. It seeks the first 0->1 transition of the status,
//   then takes BACKOFF backward steps and reports done. It reports fail if no
//   transition is found within MAX_STEPS steps of either seek phase.
//
// Ports:
//   sclk        in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   single-cycle request, honoured in IDLE/DONE/FAIL only
//   status_q    in   filtered eclk status
//   filter_clr  out  one-cycle clear pulse to the jitter filter
//   phasestep   out  PLL phase step strobe
//   phasedir    out  PLL step direction (0 forward, 1 backward)
//   phase_pos   out  net phase position, wraps mod 128
//   busy        out  alignment in progress
//   done        out  alignment succeeded (sticky until next accepted start)
//   fail        out  alignment failed (sticky until next accepted start)

module eclk_phase_align #(
    parameter int WAIT_CYCLES = 256,
    parameter int MAX_STEPS   = 64,
    parameter int STEP_PULSE  = 4,
    parameter int BACKOFF     = 2
) (
    input  logic       sclk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       status_q,
    output logic       filter_clr,
    output logic       phasestep,
    output logic       phasedir,
    output logic [6:0] phase_pos,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam int TMAX = (WAIT_CYCLES > STEP_PULSE) ? WAIT_CYCLES : STEP_PULSE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int BW   = $clog2(BACKOFF + 1) + 1;

    localparam logic [TW-1:0] WAIT_LAST  = TW'(WAIT_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(STEP_PULSE - 1);
    localparam logic [BW-1:0] BACK_TOTAL = BW'(BACKOFF);
    localparam logic [6:0]    STEP_LIMIT = 7'(MAX_STEPS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_SAMPLE,
        S_STEP,
        S_SETTLE,
        S_BACK,
        S_DONE,
        S_FAIL
    } state_t;

    // Sub-phases of a backward step sequence. B_SETUP is the single cycle in
    // which phasedir has already switched to 1 but no strobe is issued yet, so
    // the direction is stable before the first backward strobe.
    typedef enum logic [1:0] {
        B_SETUP,
        B_HIGH,
        B_LOW
    } bsub_t;

    state_t          r_state,      w_state_nxt;
    logic [TW-1:0]   r_timer,      w_timer_nxt;
    logic [6:0]      r_step_cnt,   w_step_cnt_nxt;
    logic            r_seek1,      w_seek1_nxt;
    logic [6:0]      r_pos,        w_pos_nxt;
    bsub_t           r_bsub,       w_bsub_nxt;
    logic [BW-1:0]   r_back_cnt,   w_back_cnt_nxt;

    logic            r_filter_clr, w_filter_clr_nxt;
    logic            r_phasestep,  w_phasestep_nxt;
    logic            r_phasedir,   w_phasedir_nxt;
    logic            r_busy,       w_busy_nxt;
    logic            r_done,       w_done_nxt;
    logic            r_fail,       w_fail_nxt;

    logic            w_go_step;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_step_cnt   <= '0;
            r_seek1      <= 1'b0;
            r_pos        <= '0;
            r_bsub       <= B_SETUP;
            r_back_cnt   <= '0;
            r_filter_clr <= 1'b0;
            r_phasestep  <= 1'b0;
            r_phasedir   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
            r_seek1      <= w_seek1_nxt;
            r_pos        <= w_pos_nxt;
            r_bsub       <= w_bsub_nxt;
            r_back_cnt   <= w_back_cnt_nxt;
            r_filter_clr <= w_filter_clr_nxt;
            r_phasestep  <= w_phasestep_nxt;
            r_phasedir   <= w_phasedir_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_step_cnt_nxt = r_step_cnt;
        w_seek1_nxt    = r_seek1;
        w_pos_nxt      = r_pos;
        w_bsub_nxt     = r_bsub;
        w_back_cnt_nxt = r_back_cnt;
        w_go_step      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    w_state_nxt    = S_CLEAR;
                    w_step_cnt_nxt = '0;
                    w_pos_nxt      = '0;
                    w_seek1_nxt    = 1'b0;
                end
            end

            S_CLEAR: begin
                w_state_nxt = S_WAIT;
                w_timer_nxt = '0;
            end

            S_WAIT: begin
                if (r_timer == WAIT_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            S_SAMPLE: begin
                if (!r_seek1) begin
                    // A low status (including at the very first sample) starts
                    // the search for the rising edge with a fresh step budget.
                    if (!status_q) begin
                        w_seek1_nxt    = 1'b1;
                        w_step_cnt_nxt = '0;
                    end
                    w_go_step = 1'b1;
                end else if (status_q) begin
                    if (BACKOFF > 0) begin
                        w_state_nxt    = S_BACK;
                        w_bsub_nxt     = B_SETUP;
                        w_back_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_go_step = 1'b1;
                end

                if (w_go_step) begin
                    if (w_step_cnt_nxt == STEP_LIMIT) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_state_nxt    = S_STEP;
                        w_step_cnt_nxt = w_step_cnt_nxt + 7'd1;
                        w_pos_nxt      = r_pos + 7'd1;
                        w_timer_nxt    = '0;
                    end
                end
            end

            S_STEP: begin
                if (r_timer == PULSE_LAST) begin
                    w_state_nxt = S_SETTLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            S_SETTLE: begin
                if (r_timer == PULSE_LAST) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            S_BACK: begin
                case (r_bsub)
                    B_SETUP: begin
                        w_bsub_nxt  = B_HIGH;
                        w_timer_nxt = '0;
                        w_pos_nxt   = r_pos - 7'd1;
                    end
                    B_HIGH: begin
                        if (r_timer == PULSE_LAST) begin
                            w_bsub_nxt  = B_LOW;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + TW'(1);
                        end
                    end
                    default: begin
                        if (r_timer == PULSE_LAST) begin
                            if ((r_back_cnt + BW'(1)) == BACK_TOTAL) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_back_cnt_nxt = r_back_cnt + BW'(1);
                                w_bsub_nxt     = B_HIGH;
                                w_timer_nxt    = '0;
                                w_pos_nxt      = r_pos - 7'd1;
                            end
                        end else begin
                            w_timer_nxt = r_timer + TW'(1);
                        end
                    end
                endcase
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // they line up with the state they describe.
        w_filter_clr_nxt = (w_state_nxt == S_CLEAR);
        w_busy_nxt       = !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                             (w_state_nxt == S_FAIL));
        w_done_nxt       = (w_state_nxt == S_DONE);
        w_fail_nxt       = (w_state_nxt == S_FAIL);
        w_phasedir_nxt   = (w_state_nxt == S_BACK);
        w_phasestep_nxt  = (w_state_nxt == S_STEP) ||
                           ((w_state_nxt == S_BACK) && (w_bsub_nxt == B_HIGH));
    end

    assign filter_clr = r_filter_clr;
    assign phasestep  = r_phasestep;
    assign phasedir   = r_phasedir;
    assign phase_pos  = r_pos;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;

endmodule

// File: tb/tb_eclk_phase_align.sv
// tb/tb_eclk_phase_align.sv - directed self-checking bench for eclk_phase_align

module tb_eclk_phase_align;

    localparam int W  = 256;
    localparam int MS = 64;
    localparam int SP = 4;
    localparam int BO = 2;

    logic       sclk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       status_q;
    logic       filter_clr, phasestep, phasedir, busy, done, fail;
    logic [6:0] phase_pos;

    logic       start_b;
    logic       status_b;
    logic       filter_clr_b, phasestep_b, phasedir_b, busy_b, done_b, fail_b;
    logic [6:0] phase_pos_b;

    int n_checks = 0;
    int n_pass   = 0;

    int mode       = 0;
    int fwd_base   = 0;
    int back_base  = 0;
    int viol_base  = 0;
    int fwd_b_base = 0;
    int dir1_b_base = 0;

    int fwd_cnt  = 0;
    int back_cnt = 0;
    int viol_cnt = 0;
    int fwd_b    = 0;
    int dir1_b   = 0;
    logic ps_prev = 1'b0, dir_prev = 1'b0, ps_b_prev = 1'b0;

    always #5 sclk = ~sclk;

    eclk_phase_align #(
        .WAIT_CYCLES(W), .MAX_STEPS(MS), .STEP_PULSE(SP), .BACKOFF(BO)
    ) dut (
        .sclk(sclk), .reset_n(reset_n), .start(start), .status_q(status_q),
        .filter_clr(filter_clr), .phasestep(phasestep), .phasedir(phasedir),
        .phase_pos(phase_pos), .busy(busy), .done(done), .fail(fail)
    );

    eclk_phase_align #(
        .WAIT_CYCLES(W), .MAX_STEPS(MS), .STEP_PULSE(SP), .BACKOFF(0)
    ) dut_b0 (
        .sclk(sclk), .reset_n(reset_n), .start(start_b), .status_q(status_b),
        .filter_clr(filter_clr_b), .phasestep(phasestep_b), .phasedir(phasedir_b),
        .phase_pos(phase_pos_b), .busy(busy_b), .done(done_b), .fail(fail_b)
    );

    // Status seen by the controller as a function of forward steps taken.
    function automatic logic st_fn(input int m, input int s);
        case (m)
            1:       return !((s >= 5) && (s < 8));
            2:       return (s >= 4);
            3:       return 1'b1;
            5:       return (s >= 1);
            default: return 1'b0;
        endcase
    endfunction

    assign status_q = st_fn(mode, fwd_cnt - fwd_base);
    assign status_b = ((fwd_b - fwd_b_base) >= 10);

    // Step monitor: counts strobes and direction changes near strobes.
    always @(negedge sclk) begin
        if (phasestep && !ps_prev) begin
            if (phasedir) back_cnt++;
            else fwd_cnt++;
            if (phasedir !== dir_prev) viol_cnt++;
        end
        if (phasestep && ps_prev && (phasedir !== dir_prev)) viol_cnt++;
        ps_prev  = phasestep;
        dir_prev = phasedir;
        if (phasestep_b && !ps_b_prev) fwd_b++;
        if (phasedir_b) dir1_b++;
        ps_b_prev = phasestep_b;
    end

    task automatic pulse_start;
        @(negedge sclk);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int lim, output bit to, output logic bprev, output logic bnow);
        logic bp;
        to    = 1'b1;
        bprev = 1'bx;
        bnow  = 1'bx;
        bp    = busy;
        for (int i = 0; i < lim; i++) begin
            @(negedge sclk);
            if (done || fail) begin
                to    = 1'b0;
                bprev = bp;
                bnow  = busy;
                break;
            end
            bp = busy;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        #12;
        n_checks++; if ({filter_clr, phasestep, phasedir, busy, done, fail} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000", {filter_clr, phasestep, phasedir, busy, done, fail});
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd0) $display("FAIL reset_pos: got %0d expected 0", phase_pos);
        else n_pass++;
        @(negedge sclk);
        reset_n = 1'b1;
        repeat (3) @(negedge sclk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic;
        bit to; logic bp, bn;
        mode = 1; fwd_base = fwd_cnt; back_base = back_cnt; viol_base = viol_cnt;
        pulse_start;
        n_checks++; if (filter_clr !== 1'b1) $display("FAIL start_clr: got %b expected 1", filter_clr);
        else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b expected 1", busy);
        else n_pass++;
        @(negedge sclk);
        n_checks++; if (filter_clr !== 1'b0) $display("FAIL clr_width: got %b expected 0", filter_clr);
        else n_pass++;
        wait_end(5000, to, bp, bn);
        n_checks++; if (to) $display("FAIL basic_timeout: got timeout expected done");
        else n_pass++;
        n_checks++; if ({bp, bn} !== 2'b10) $display("FAIL basic_busy_edge: got %b expected 10", {bp, bn});
        else n_pass++;
        n_checks++; if ({done, fail} !== 2'b10) $display("FAIL basic_result: got %b expected 10", {done, fail});
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd6) $display("FAIL basic_pos: got %0d expected 6", phase_pos);
        else n_pass++;
        n_checks++; if (fwd_cnt - fwd_base !== 8) $display("FAIL basic_fwd: got %0d expected 8", fwd_cnt - fwd_base);
        else n_pass++;
        n_checks++; if (back_cnt - back_base !== 2) $display("FAIL basic_back: got %0d expected 2", back_cnt - back_base);
        else n_pass++;
        n_checks++; if (viol_cnt - viol_base !== 0) $display("FAIL basic_dir_stable: got %0d expected 0", viol_cnt - viol_base);
        else n_pass++;
        n_checks++; if (phasedir !== 1'b0) $display("FAIL basic_dir_done: got %b expected 0", phasedir);
        else n_pass++;
    endtask

    task automatic test_seek1_immediate;
        bit to; logic bp, bn;
        mode = 2; fwd_base = fwd_cnt; back_base = back_cnt;
        pulse_start;
        n_checks++; if (done !== 1'b0) $display("FAIL restart_done_clear: got %b expected 0", done);
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd0) $display("FAIL restart_pos: got %0d expected 0", phase_pos);
        else n_pass++;
        wait_end(5000, to, bp, bn);
        n_checks++; if (to || done !== 1'b1) $display("FAIL seek1_done: got %b expected 1", done);
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd2) $display("FAIL seek1_pos: got %0d expected 2", phase_pos);
        else n_pass++;
        n_checks++; if (fwd_cnt - fwd_base !== 4) $display("FAIL seek1_fwd: got %0d expected 4", fwd_cnt - fwd_base);
        else n_pass++;
    endtask

    task automatic test_wrap;
        bit to; logic bp, bn;
        mode = 5; fwd_base = fwd_cnt; back_base = back_cnt;
        pulse_start;
        wait_end(3000, to, bp, bn);
        n_checks++; if (to || done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", done);
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd127) $display("FAIL wrap_pos: got %0d expected 127", phase_pos);
        else n_pass++;
        n_checks++; if (back_cnt - back_base !== 2) $display("FAIL wrap_back: got %0d expected 2", back_cnt - back_base);
        else n_pass++;
    endtask

    task automatic test_stuck;
        bit to; logic bp, bn;
        mode = 3; fwd_base = fwd_cnt; back_base = back_cnt;
        pulse_start;
        wait_end(20000, to, bp, bn);
        n_checks++; if (to) $display("FAIL stuck_timeout: got timeout expected fail");
        else n_pass++;
        n_checks++; if ({done, fail, busy} !== 3'b010) $display("FAIL stuck_result: got %b expected 010", {done, fail, busy});
        else n_pass++;
        n_checks++; if ({bp, bn} !== 2'b10) $display("FAIL stuck_busy_edge: got %b expected 10", {bp, bn});
        else n_pass++;
        n_checks++; if (fwd_cnt - fwd_base !== MS) $display("FAIL stuck_steps: got %0d expected %0d", fwd_cnt - fwd_base, MS);
        else n_pass++;
        n_checks++; if (back_cnt - back_base !== 0) $display("FAIL stuck_back: got %0d expected 0", back_cnt - back_base);
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd64) $display("FAIL stuck_pos: got %0d expected 64", phase_pos);
        else n_pass++;
    endtask

    task automatic test_backoff0;
        bit got;
        fwd_b_base = fwd_b; dir1_b_base = dir1_b;
        @(negedge sclk); start_b = 1'b1;
        @(negedge sclk); start_b = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge sclk);
            if (done_b || fail_b) begin got = 1'b1; break; end
        end
        n_checks++; if (!got || {done_b, fail_b, busy_b} !== 3'b100)
            $display("FAIL b0_result: got %b expected 100", {done_b, fail_b, busy_b});
        else n_pass++;
        n_checks++; if (phase_pos_b !== 7'd10) $display("FAIL b0_pos: got %0d expected 10", phase_pos_b);
        else n_pass++;
        n_checks++; if (dir1_b - dir1_b_base !== 0) $display("FAIL b0_dir: got %0d cycles expected 0", dir1_b - dir1_b_base);
        else n_pass++;
        n_checks++; if (fwd_b - fwd_b_base !== 10) $display("FAIL b0_fwd: got %0d expected 10", fwd_b - fwd_b_base);
        else n_pass++;
    endtask

    task automatic test_reset_midstep;
        bit got; bit to; logic bp, bn;
        mode = 3; fwd_base = fwd_cnt;
        pulse_start;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (phasestep) begin got = 1'b1; break; end
        end
        n_checks++; if (!got) $display("FAIL midstep_reach: got no phasestep expected pulse");
        else n_pass++;
        @(negedge sclk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({filter_clr, phasestep, phasedir, busy, done, fail} !== 6'b0)
            $display("FAIL midstep_flags: got %b expected 000000", {filter_clr, phasestep, phasedir, busy, done, fail});
        else n_pass++;
        n_checks++; if (phase_pos !== 7'd0) $display("FAIL midstep_pos: got %0d expected 0", phase_pos);
        else n_pass++;
        @(negedge sclk);
        reset_n = 1'b1;
        mode = 2; fwd_base = fwd_cnt;
        pulse_start;
        n_checks++; if ({busy, filter_clr} !== 2'b11 || phase_pos !== 7'd0)
            $display("FAIL rerun_start: got busy/clr %b pos %0d expected 11 pos 0", {busy, filter_clr}, phase_pos);
        else n_pass++;
        wait_end(5000, to, bp, bn);
        n_checks++; if (to || done !== 1'b1 || phase_pos !== 7'd2)
            $display("FAIL rerun_result: got done %b pos %0d expected 1 pos 2", done, phase_pos);
        else n_pass++;
    endtask

    task automatic test_start_during_wait;
        int k; int k2; int clr_seen; bit got;
        mode = 3; fwd_base = fwd_cnt;
        pulse_start;
        k = 0; clr_seen = 0; got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            k++;
            if (k == 50) start = 1'b1;
            if (k == 51) start = 1'b0;
            if (filter_clr) clr_seen++;
            if (phasestep) begin got = 1'b1; break; end
        end
        n_checks++; if (!got || k !== W + 2) $display("FAIL clr_to_step: got %0d expected %0d", k, W + 2);
        else n_pass++;
        n_checks++; if (clr_seen !== 0) $display("FAIL ignored_start_clr: got %0d expected 0", clr_seen);
        else n_pass++;
        k2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            k2++;
            if (filter_clr) break;
        end
        n_checks++; if (k2 !== 2 * SP) $display("FAIL step_to_clr: got %0d expected %0d", k2, 2 * SP);
        else n_pass++;
        n_checks++; if (busy !== 1'b1 || fwd_cnt - fwd_base !== 1)
            $display("FAIL wait_seq: got busy %b steps %0d expected 1 steps 1", busy, fwd_cnt - fwd_base);
        else n_pass++;
        @(negedge sclk); reset_n = 1'b0;
        @(negedge sclk); reset_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_seek1_immediate;
        test_wrap;
        test_stuck;
        test_backoff0;
        test_reset_midstep;
        test_start_during_wait;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
